// File: rtl/lza_normalizer.sv
// lza_normalizer: post-LZA normalisation of a significand.
// A captured leading-zero prediction drives a log-stage left shifter, one
// stage per clock. A final one-bit correction covers an LZA under-prediction.
// The exponent is then reduced by the total shift, saturating at zero and
// flagging underflow. The result is held in DONE until the downstream side
// accepts it.
module lza_normalizer #(
    parameter int SWR = 26,
    parameter int EWR = 5,
    parameter int EW  = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start_i,
    input  logic [SWR-1:0] Sgf_i,
    input  logic [EW-1:0]  Exp_i,
    input  logic [EWR-1:0] Shift_Value_i,
    input  logic           ready_i,
    output logic           busy_o,
    output logic           valid_o,
    output logic [SWR-1:0] Sgf_o,
    output logic [EW-1:0]  Exp_o,
    output logic           zero_o,
    output logic           underflow_o
);

    localparam int KW = (EWR > 1) ? $clog2(EWR) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(EWR - 1);
    localparam int MAX_SH = SWR - 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        FIX   = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t         state;
    logic [KW-1:0]  k;
    logic [EWR-1:0] shamt;
    logic [SWR-1:0] work;
    logic [EW-1:0]  exp_q;

    logic           fix_bit;
    logic [SWR-1:0] fix_sgf;
    logic [EW:0]    total;
    logic [EW:0]    exp_res;

    // A prediction larger than the significand can hold is meaningless;
    // limit it to the widest useful shift.
    function automatic logic [EWR-1:0] clamp_shift(input logic [EWR-1:0] sh);
        if (int'(sh) > MAX_SH)
            return EWR'(MAX_SH);
        else
            return sh;
    endfunction

    // One stage of the log shifter: a shift by 2^stage when its enable bit is set.
    function automatic logic [SWR-1:0] shift_stage(input logic [SWR-1:0] w,
                                                   input logic           en,
                                                   input logic [KW-1:0]  stage);
        if (en)
            return w << (32'd1 << stage);
        else
            return w;
    endfunction

    // Exponent minus total shift, saturated at zero.
    // The result is {underflow, exponent}.
    function automatic logic [EW:0] sat_exp(input logic [EW-1:0] e,
                                            input logic [EW:0]   tot);
        logic signed [EW+1:0] diff;
        diff = $signed({2'b00, e}) - $signed({1'b0, tot});
        if (diff[EW+1] || (diff == '0))
            return {1'b1, {EW{1'b0}}};
        else
            return {1'b0, diff[EW-1:0]};
    endfunction

    // Final correction and exponent adjustment, evaluated during FIX.
    always_comb begin
        fix_bit = ~work[SWR-1];
        fix_sgf = work;
        if (fix_bit)
            fix_sgf = {work[SWR-2:0], 1'b0};
        total   = (EW+1)'(shamt) + (EW+1)'(fix_bit);
        exp_res = sat_exp(exp_q, total);
    end

    // Control FSM, working registers and registered result outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            k           <= '0;
            shamt       <= '0;
            work        <= '0;
            exp_q       <= '0;
            busy_o      <= 1'b0;
            valid_o     <= 1'b0;
            Sgf_o       <= '0;
            Exp_o       <= '0;
            zero_o      <= 1'b0;
            underflow_o <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_i) begin
                        busy_o <= 1'b1;
                        if (Sgf_i == '0) begin
                            // A zero significand has no leading one.
                            // Report it directly.
                            state       <= DONE;
                            valid_o     <= 1'b1;
                            Sgf_o       <= '0;
                            Exp_o       <= '0;
                            zero_o      <= 1'b1;
                            underflow_o <= 1'b0;
                        end else begin
                            state <= SHIFT;
                            work  <= Sgf_i;
                            exp_q <= Exp_i;
                            shamt <= clamp_shift(Shift_Value_i);
                            k     <= '0;
                        end
                    end
                end
                SHIFT: begin
                    work <= shift_stage(work, shamt[k], k);
                    if (k == K_LAST) begin
                        state <= FIX;
                        k     <= '0;
                    end else begin
                        k <= k + 1'b1;
                    end
                end
                FIX: begin
                    // Over-prediction loses shifted-out bits silently; the
                    // upstream LZA guarantees exact or one-short predictions.
                    state       <= DONE;
                    valid_o     <= 1'b1;
                    work        <= fix_sgf;
                    Sgf_o       <= fix_sgf;
                    Exp_o       <= exp_res[EW-1:0];
                    underflow_o <= exp_res[EW];
                    zero_o      <= 1'b0;
                end
                DONE: begin
                    if (ready_i) begin
                        state   <= IDLE;
                        valid_o <= 1'b0;
                        busy_o  <= 1'b0;
                    end
                end
                default: begin
                    state   <= IDLE;
                    valid_o <= 1'b0;
                    busy_o  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lza_normalizer.sv
// Directed-vector bench for lza_normalizer with hand-computed expectations.
module tb_lza_normalizer;

    logic        clk;
    logic        rst;
    logic        start_i;
    logic [25:0] Sgf_i;
    logic [7:0]  Exp_i;
    logic [4:0]  Shift_Value_i;
    logic        ready_i;
    logic        busy_o;
    logic        valid_o;
    logic [25:0] Sgf_o;
    logic [7:0]  Exp_o;
    logic        zero_o;
    logic        underflow_o;

    int n_vec = 0;
    int n_err = 0;

    lza_normalizer #(.SWR(26), .EWR(5), .EW(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .start_i      (start_i),
        .Sgf_i        (Sgf_i),
        .Exp_i        (Exp_i),
        .Shift_Value_i(Shift_Value_i),
        .ready_i      (ready_i),
        .busy_o       (busy_o),
        .valid_o      (valid_o),
        .Sgf_o        (Sgf_o),
        .Exp_o        (Exp_o),
        .zero_o       (zero_o),
        .underflow_o  (underflow_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h", tag, got, want);
        end
    endtask

    // Issue one operand from IDLE and check the result. The latency counts
    // edges from the one that samples start_i to the one that raises valid_o.
    task automatic op(input logic [25:0] s, input logic [7:0] e, input logic [4:0] sh,
                      input int want_lat, input logic [25:0] w_sgf, input logic [7:0] w_exp,
                      input logic w_zero, input logic w_uf, input string tag, input bit handshake);
        int lat;
        start_i = 1'b1;
        Sgf_i = s;
        Exp_i = e;
        Shift_Value_i = sh;
        @(posedge clk); #1;
        start_i = 1'b0;
        lat = 1;
        while (!valid_o && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        chk({tag, "_lat"}, 64'(lat), 64'(want_lat));
        chk({tag, "_sgf"}, 64'(Sgf_o), 64'(w_sgf));
        chk({tag, "_exp"}, 64'(Exp_o), 64'(w_exp));
        chk({tag, "_zero"}, 64'(zero_o), 64'(w_zero));
        chk({tag, "_uf"}, 64'(underflow_o), 64'(w_uf));
        chk({tag, "_busy"}, 64'(busy_o), 64'd1);
        if (handshake) begin
            ready_i = 1'b1;
            @(posedge clk); #1;
            ready_i = 1'b0;
            chk({tag, "_vld_clr"}, 64'(valid_o), 64'd0);
            chk({tag, "_idle"}, 64'(busy_o), 64'd0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        start_i = 1'b0;
        ready_i = 1'b0;
        Sgf_i = '0;
        Exp_i = '0;
        Shift_Value_i = '0;
        #2 rst = 1'b0;
        #1;
        chk("rst_busy", 64'(busy_o), 64'd0);
        chk("rst_valid", 64'(valid_o), 64'd0);
        chk("rst_sgf", 64'(Sgf_o), 64'd0);
        chk("rst_exp", 64'(Exp_o), 64'd0);
        chk("rst_zero", 64'(zero_o), 64'd0);
        chk("rst_uf", 64'(underflow_o), 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b1;
        @(posedge clk); #1;

        op(26'h0100000, 8'd100, 5'd5, 7, 26'h2000000, 8'd95, 1'b0, 1'b0, "base", 1'b1);
        op(26'h0080000, 8'd100, 5'd5, 7, 26'h2000000, 8'd94, 1'b0, 1'b0, "under", 1'b1);
        op(26'h0000000, 8'd77, 5'd13, 1, 26'h0000000, 8'd0, 1'b1, 1'b0, "zero", 1'b1);
        op(26'h0000001, 8'd10, 5'd25, 7, 26'h2000000, 8'd0, 1'b0, 1'b1, "uf25", 1'b1);
        op(26'h0000001, 8'd10, 5'd31, 7, 26'h2000000, 8'd0, 1'b0, 1'b1, "clamp", 1'b1);
        op(26'h0100000, 8'd5, 5'd5, 7, 26'h2000000, 8'd0, 1'b0, 1'b1, "ufeq", 1'b1);
        op(26'h0100000, 8'd6, 5'd5, 7, 26'h2000000, 8'd1, 1'b0, 1'b0, "ufedge", 1'b1);
        op(26'h2345678, 8'd3, 5'd0, 7, 26'h2345678, 8'd3, 1'b0, 1'b0, "noshift", 1'b1);
        op(26'h0000003, 8'd200, 5'd23, 7, 26'h3000000, 8'd176, 1'b0, 1'b0, "mix", 1'b1);

        // Back-pressure: result held while start_i pulses are ignored.
        op(26'h0000F00, 8'd50, 5'd13, 7, 26'h3C00000, 8'd36, 1'b0, 1'b0, "stall", 1'b0);
        for (int i = 0; i < 3; i++) begin
            start_i = 1'b1;
            Sgf_i = 26'h0000055;
            Exp_i = 8'd9;
            Shift_Value_i = 5'd3;
            @(posedge clk); #1;
            start_i = 1'b0;
            chk("stall_vld", 64'(valid_o), 64'd1);
            chk("stall_sgf", 64'(Sgf_o), 64'h3C00000);
            chk("stall_exp", 64'(Exp_o), 64'd36);
            chk("stall_busy", 64'(busy_o), 64'd1);
        end
        // Transfer edge with start_i high: the zero operand must not be taken.
        ready_i = 1'b1;
        start_i = 1'b1;
        Sgf_i = '0;
        @(posedge clk); #1;
        ready_i = 1'b0;
        start_i = 1'b0;
        chk("xfer_vld", 64'(valid_o), 64'd0);
        chk("xfer_busy", 64'(busy_o), 64'd0);
        chk("hold_sgf", 64'(Sgf_o), 64'h3C00000);
        chk("hold_exp", 64'(Exp_o), 64'd36);
        chk("hold_zero", 64'(zero_o), 64'd0);

        // Reset in the third SHIFT cycle abandons the operation.
        start_i = 1'b1;
        Sgf_i = 26'h0100000;
        Exp_i = 8'd100;
        Shift_Value_i = 5'd5;
        @(posedge clk); #1;
        start_i = 1'b0;
        repeat (2) begin
            @(posedge clk); #1;
        end
        chk("mid_busy", 64'(busy_o), 64'd1);
        rst = 1'b0;
        #1;
        chk("mid_rst_busy", 64'(busy_o), 64'd0);
        chk("mid_rst_vld", 64'(valid_o), 64'd0);
        chk("mid_rst_sgf", 64'(Sgf_o), 64'd0);
        chk("mid_rst_exp", 64'(Exp_o), 64'd0);
        #2 rst = 1'b1;
        repeat (8) begin
            @(posedge clk); #1;
        end
        chk("post_rst_vld", 64'(valid_o), 64'd0);
        chk("post_rst_busy", 64'(busy_o), 64'd0);
        op(26'h0100000, 8'd100, 5'd5, 7, 26'h2000000, 8'd95, 1'b0, 1'b0, "rerun", 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/lza_normalizer.md
LZA_NORMALIZER -- requirements
Module: lza_normalizer

Interface
REQ-001 SHALL have parameter SWR, default 26: significand width in bits.
REQ-002 SHALL have parameter EWR, default 5: shift-count width in bits.
REQ-003 SHALL have parameter EW, default 8: exponent width in bits.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state SHALL change on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: reset, asynchronous and active-low.
REQ-006 SHALL have port start_i, input, 1 bit: request to load operands; sampled only in IDLE.
REQ-007 SHALL have port Sgf_i, input, SWR bits: significand to be normalised.
REQ-008 SHALL have port Exp_i, input, EW bits: unsigned biased exponent of Sgf_i.
REQ-009 SHALL have port Shift_Value_i, input, EWR bits: predicted leading-zero count from the LZA output register.
REQ-010 SHALL have port ready_i, input, 1 bit: downstream accepts the result.
REQ-011 SHALL have port busy_o, output, 1 bit: high whenever state is not IDLE.
REQ-012 SHALL have port valid_o, output, 1 bit: result valid, high only in DONE.
REQ-013 SHALL have port Sgf_o, output, SWR bits: normalised significand.
REQ-014 SHALL have port Exp_o, output, EW bits: adjusted exponent.
REQ-015 SHALL have port zero_o, output, 1 bit: the input significand was zero.
REQ-016 SHALL have port underflow_o, output, 1 bit: the exponent adjustment reached or passed zero.

Function
REQ-017 SHALL implement the FSM states IDLE, SHIFT, FIX and DONE, all encoded in registers.
REQ-018 In IDLE with start_i=1 and Sgf_i=0, the next edge SHALL enter DONE with Sgf_o=0, Exp_o=0 and zero_o=1; this is a 1-cycle latency.
REQ-019 In IDLE with start_i=1 and Sgf_i nonzero, the next edge SHALL capture Sgf_i, Exp_i and Shift_Value_i, clamp the captured shift to SWR-1 if it exceeds SWR-1, clear stage counter k to 0, and enter SHIFT.
REQ-020 Each SHIFT edge SHALL shift the working significand left by 2^k if captured shift bit k is set, zero-filling from the right, then increment k; when k=EWR-1 the same edge SHALL enter FIX.
REQ-021 On the FIX edge, if the working MSB is 0, the block SHALL shift left by 1 more and set fix=1 (LZA under-prediction by one); otherwise fix=0. The same edge SHALL enter DONE.
REQ-022 Nonzero-operand latency SHALL be EWR+1 edges from the capture edge to valid_o high (6 for EWR=5).
REQ-023 Exponent arithmetic SHALL be EW+1 bits wide: total = shift + fix.
REQ-024 If total >= Exp_i, then Exp_o=0 and underflow_o=1; otherwise Exp_o = Exp_i - total and underflow_o=0. Sgf_o SHALL be the shifted value in both cases.
REQ-025 Bits shifted out by an LZA over-prediction SHALL be discarded without a flag; the upstream block guarantees the shift is exact or one less.
REQ-026 In DONE, all outputs SHALL hold stable while ready_i=0; an edge with valid_o=1 and ready_i=1 SHALL return to IDLE and clear valid_o.
REQ-027 start_i SHALL be ignored in SHIFT, FIX and DONE; a new operand SHALL NOT be accepted on the transfer edge and needs IDLE first.
REQ-028 Sgf_o, Exp_o, zero_o and underflow_o SHALL be registered and SHALL keep their last values after leaving DONE until the next result is produced.

Reset
REQ-029 While rst=0, regardless of clk, the state SHALL be IDLE, k=0, and busy_o, valid_o, Sgf_o, Exp_o, zero_o and underflow_o SHALL all be 0.
REQ-030 Reset asserted mid-operation SHALL abandon the operation with no result emitted; the first start_i after rst rises SHALL be processed normally.

Verification
REQ-031 Sgf_i=26'h0100000, Exp_i=100, Shift_Value_i=5 -> valid_o high 6 edges after capture; Sgf_o=26'h2000000, Exp_o=95, underflow_o=0, zero_o=0.
REQ-032 Under-prediction: Sgf_i=26'h0080000, Exp_i=100, Shift_Value_i=5 -> FIX shifts 1; Sgf_o=26'h2000000, Exp_o=94.
REQ-033 Sgf_i=0, Exp_i=77, any shift -> valid_o high 1 edge after capture; zero_o=1, Sgf_o=0, Exp_o=0.
REQ-034 Sgf_i=26'h0000001, Exp_i=10, Shift_Value_i=25 -> Sgf_o=26'h2000000, Exp_o=0, underflow_o=1; also Shift_Value_i=31 -> clamped to 25, same result.
REQ-035 ready_i held 0 for 3 cycles in DONE while start_i pulses -> outputs stable, pulses ignored; ready_i=1 -> one transfer, then IDLE with busy_o=0.
REQ-036 rst pulsed low in the third SHIFT cycle -> all outputs 0 immediately with no valid_o; the next start with REQ-031 values gives the REQ-031 result.
